// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each operation is captured after EXEC_CYCLES settle cycles and held until the consumer accepts it.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [7:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    logic [1:0]  state;
    logic        prio;
    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_code;
    logic        op_id;

    logic        grant;
    logic        grant_id;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [3:0]  sel_op;

    function automatic logic is_legal(input logic [3:0] op);
        return (op == 4'b1000) || (op == 4'b1001) || (op == 4'b1100) || (op == 4'b1101);
    endfunction

    always_comb begin
        grant_id  = (req_valid == 2'b11) ? prio : req_valid[1];
        grant     = (state == IDLE) && (req_valid != 2'b00);
        req_ready = '0;
        if (grant)
            req_ready[grant_id] = 1'b1;
        sel_a  = grant_id ? req_a[63:32] : req_a[31:0];
        sel_b  = grant_id ? req_b[63:32] : req_b[31:0];
        sel_op = grant_id ? req_op[7:4]  : req_op[3:0];
    end

    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign alu_opcode = is_legal(op_code) ? op_code : '0;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            cnt          <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_code      <= '0;
            op_id        <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        op_a    <= sel_a;
                        op_b    <= sel_b;
                        op_code <= sel_op;
                        op_id   <= grant_id;
                        prio    <= ~grant_id;
                        if (is_legal(sel_op)) begin
                            state <= EXEC;
                            cnt   <= CNT_INIT;
                        end else begin
                            // Illegal ops never reach the ALU; respond with an error immediately.
                            state        <= RESP;
                            rsp_id       <= grant_id;
                            rsp_result   <= '0;
                            rsp_carry    <= 1'b0;
                            rsp_overflow <= 1'b0;
                            rsp_zero     <= 1'b0;
                            rsp_err      <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        rsp_id       <= op_id;
                        rsp_result   <= alu_result;
                        rsp_carry    <= alu_carry;
                        rsp_overflow <= alu_overflow;
                        rsp_zero     <= alu_zero;
                        rsp_err      <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
